gshare_predictor: RTL and testbench
===================================

// Module: gshare_predictor
// PURPOSE
//  Global-history branch direction predictor: table of 2**IDX_W saturating
//  counters indexed by PC bits XOR a speculative global history register (GHR).
//  Predicts in fetch (combinational read), trains at branch resolution in EX,
//  repairs the GHR on mispredict. Generalises the 16x2-bit PHT in table depth,
//  counter width and history length, and adds history and repair.
// PARAMETERS
//  IDX_W   4  table index width; entries = 2**IDX_W
//  HIST_W  4  GHR length; 1 <= HIST_W <= IDX_W
//  CTR_W   2  counter width; 2 <= CTR_W <= 4
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  rst              in   1       reset, asynchronous, active-high
//  pred_valid       in   1       fetch holds a branch this cycle
//  pred_pc          in   IDX_W   PC index bits of fetched branch
//  pred_taken       out  1       predicted direction
//  pred_idx         out  IDX_W   table index used; carried down pipeline
//  pred_ghr         out  HIST_W  GHR before this prediction; carried down pipeline
//  upd_valid        in   1       a branch resolves this cycle
//  upd_idx          in   IDX_W   pred_idx carried with that branch
//  upd_ghr          in   HIST_W  pred_ghr carried with that branch
//  upd_taken        in   1       actual direction
//  upd_mispredict   in   1       actual != predicted; qualified by upd_valid
// BEHAVIOUR
//  - Reset (async assert, clears immediately): every counter = 2**(CTR_W-1)-1
//    (weakly not-taken; 2'b01 at CTR_W=2); GHR = 0. Outputs follow
//    combinationally: pred_taken=0, pred_ghr=0, pred_idx=pred_pc.
//  - Index: pred_idx = pred_pc ^ {{(IDX_W-HIST_W){1'b0}}, ghr}. Pure
//    combinational; pred_taken = ctr[pred_idx][CTR_W-1] (MSB = taken). Zero latency.
//  - pred_* outputs are valid whether or not pred_valid is high; pred_valid
//    gates only the GHR update.
//  - GHR next state, priority order:
//    1) upd_valid & upd_mispredict: ghr <= {upd_ghr[HIST_W-2:0], upd_taken}
//       (for HIST_W=1: ghr <= upd_taken). A same-cycle pred_valid shift is
//       discarded; the younger branch is squashed by the pipeline.
//    2) else pred_valid: ghr <= {ghr[HIST_W-2:0], pred_taken}
//    3) else hold.
//  - Counter training on upd_valid at posedge, independent of upd_mispredict:
//    taken: ctr[upd_idx] +1 unless already all-ones (saturate);
//    not taken: -1 unless already zero (saturate). Exactly one entry changes per cycle.
//  - Read/write collision (pred_idx == upd_idx in one cycle): prediction uses
//    the pre-update value; the new value is visible from the next cycle.
//    No bypass.
//  - Correct predictions never alter the GHR on the update path; the
//    speculative shift already recorded them.
//  - rst mid-operation: all state returns to reset values in the same
//    timestep; in-flight updates are lost. After deassert, first posedge
//    behaves as from reset.
//  - Storage: flops (no inferred RAM). Counters need the async reset and a
//    same-cycle combinational read.
// TESTING
//  1) Reset, defaults: pred_pc=0..15 each -> pred_taken=0, pred_ghr=0,
//     pred_idx=pred_pc.
//  2) Saturation, CTR_W=2, idx 5: 3x upd_taken=1 -> ctr 01->10->11->11,
//     pred_taken=1 after first; 4x not-taken -> 10,01,00,00; pred_taken=0 from 2nd.
//  3) GHR shift: pred_valid 4 cycles, counters forced taken -> ghr
//     0000,0001,0011,0111,1111; pred_pc=4'h3 with ghr=4'hF -> pred_idx=4'hC.
//  4) Repair beats shift: ghr=4'b1010, same cycle pred_valid=1,
//     upd_mispredict=1, upd_ghr=4'b0110, upd_taken=1 -> next ghr=4'b1101.
//  5) Collision: ctr[7]=01, pred_pc^ghr=7 and upd_idx=7 taken in one cycle
//     -> pred_taken=0 that cycle, 1 next cycle.
//  6) Async reset mid-run: assert rst between edges after random traffic ->
//     ghr=0 and all counters weakly not-taken before next posedge; rerun
//     1) with HIST_W=2, IDX_W=6, CTR_W=3.

Source files
------------

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: a table of saturating counters indexed by
// PC XOR a speculative global history register, repaired on mispredict.
module gshare_predictor #(
  parameter int IDX_W  = 4,
  parameter int HIST_W = 4,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [IDX_W-1:0]  pred_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_mispredict
);

  localparam int               ENTRIES  = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);

  logic [CTR_W-1:0]  ctr [ENTRIES];
  logic [HIST_W-1:0] ghr;
  logic [HIST_W:0]   repair_cat;
  logic [HIST_W:0]   shift_cat;

  function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] c,
                                                 input logic taken);
    if (taken) return (&c) ? c : c + CTR_W'(1);
    else       return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  assign pred_idx   = pred_pc ^ IDX_W'(ghr);
  assign pred_taken = ctr[pred_idx][CTR_W-1];
  assign pred_ghr   = ghr;

  // Dropping the top bit of the concatenation is the history shift; this form
  // also covers a one-bit history without a special case.
  assign repair_cat = {upd_ghr, upd_taken};
  assign shift_cat  = {ghr, pred_taken};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (upd_valid && upd_mispredict) begin
      ghr <= repair_cat[HIST_W-1:0];
    end else if (pred_valid) begin
      ghr <= shift_cat[HIST_W-1:0];
    end
  end

  // Training ignores upd_mispredict; reads in the same cycle see the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (upd_valid) begin
      ctr[upd_idx] <= ctr_train(ctr[upd_idx], upd_taken);
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: default configuration against an array/arithmetic
// model, plus a wide configuration (IDX_W=6, HIST_W=2, CTR_W=3) for reset checks.
`timescale 1ns/100ps
module tb_gshare_predictor;

  logic clk = 1'b0;
  logic rst;

  logic       pv, ptaken, uv, ut, um;
  logic [3:0] ppc, pidx, pghr, uidx, ughr;

  logic       b_pv, b_ptaken, b_uv, b_ut, b_um;
  logic [5:0] b_ppc, b_pidx, b_uidx;
  logic [1:0] b_pghr, b_ughr;

  int  n_vec = 0;
  int  n_err = 0;
  int  m_ctr [16];
  int  m_ghr;
  bit  b_rand = 0;
  bit  obs_taken;
  int  obs_ghr, obs_idx;

  always #10 clk = ~clk;

  gshare_predictor #(.IDX_W(4), .HIST_W(4), .CTR_W(2)) dut_a (
    .clk(clk), .rst(rst), .pred_valid(pv), .pred_pc(ppc), .pred_taken(ptaken),
    .pred_idx(pidx), .pred_ghr(pghr), .upd_valid(uv), .upd_idx(uidx),
    .upd_ghr(ughr), .upd_taken(ut), .upd_mispredict(um));

  gshare_predictor #(.IDX_W(6), .HIST_W(2), .CTR_W(3)) dut_b (
    .clk(clk), .rst(rst), .pred_valid(b_pv), .pred_pc(b_ppc), .pred_taken(b_ptaken),
    .pred_idx(b_pidx), .pred_ghr(b_pghr), .upd_valid(b_uv), .upd_idx(b_uidx),
    .upd_ghr(b_ughr), .upd_taken(b_ut), .upd_mispredict(b_um));

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_ghr = 0;
  endtask

  // One clock of traffic on the default instance, checked before the edge.
  task automatic cycle(input bit pvi, input int pci, input bit uvi, input int uii,
                       input int ugi, input bit uti, input bit umi);
    int ei;
    bit et;
    @(negedge clk);
    pv = pvi; ppc = 4'(pci); uv = uvi; uidx = 4'(uii); ughr = 4'(ugi);
    ut = uti; um = umi;
    if (b_rand) begin
      b_pv = 1'($urandom); b_ppc = 6'($urandom); b_uv = 1'($urandom);
      b_uidx = 6'($urandom); b_ughr = 2'($urandom); b_ut = 1'($urandom);
      b_um = 1'($urandom);
    end else begin
      b_pv = 0; b_uv = 0; b_um = 0;
    end
    #1;
    ei = (pci % 16) ^ m_ghr;
    et = (m_ctr[ei] >= 2);
    obs_taken = ptaken; obs_ghr = int'(pghr); obs_idx = int'(pidx);
    n_vec++;
    if (pidx !== 4'(ei)) begin
      n_err++; $display("FAIL pred_idx got %0h expected %0h", pidx, ei);
    end
    n_vec++;
    if (ptaken !== et) begin
      n_err++; $display("FAIL pred_taken idx %0h got %0b expected %0b", ei, ptaken, et);
    end
    n_vec++;
    if (pghr !== 4'(m_ghr)) begin
      n_err++; $display("FAIL pred_ghr got %0h expected %0h", pghr, m_ghr);
    end
    @(posedge clk);
    if (uvi) begin
      if (uti) m_ctr[uii % 16] = (m_ctr[uii % 16] < 3) ? m_ctr[uii % 16] + 1 : 3;
      else     m_ctr[uii % 16] = (m_ctr[uii % 16] > 0) ? m_ctr[uii % 16] - 1 : 0;
    end
    if (uvi && umi)  m_ghr = ((ugi % 16) * 2 + int'(uti)) % 16;
    else if (pvi)    m_ghr = (m_ghr * 2 + int'(et)) % 16;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int pc = 0; pc < 16; pc++) begin
      ppc = 4'(pc);
      #0.5;
      n_vec++;
      if (ptaken !== 1'b0 || pghr !== 4'h0 || pidx !== 4'(pc)) begin
        n_err++;
        $display("FAIL reset_default pc %0h got taken=%0b ghr=%0h idx=%0h expected 0/0/%0h",
                 pc, ptaken, pghr, pidx, pc);
      end
    end
  endtask

  task automatic test_saturation();
    bit exp_t [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    for (int k = 0; k < 8; k++) begin
      cycle(0, 5, (k < 7), 5, 0, (k < 3), 0);
      n_vec++;
      if (obs_taken !== exp_t[k]) begin
        n_err++; $display("FAIL saturation step %0d got %0b expected %0b", k, obs_taken, exp_t[k]);
      end
    end
  endtask

  task automatic test_ghr_shift();
    int exp_g [5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, i, 0, 1, 0);
      cycle(0, 0, 1, i, 0, 1, 0);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) cycle(1, int'($urandom_range(0, 15)), 0, 0, 0, 0, 0);
      else       cycle(0, 3, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs_ghr != exp_g[k]) begin
        n_err++; $display("FAIL ghr_shift step %0d got %0h expected %0h", k, obs_ghr, exp_g[k]);
      end
    end
    n_vec++;
    if (obs_idx != 4'hC) begin
      n_err++; $display("FAIL ghr_index got %0h expected c", obs_idx);
    end
  endtask

  task automatic test_repair();
    cycle(0, 0, 1, 2, 4'b0101, 0, 1);
    cycle(1, 9, 1, 4, 4'b0110, 1, 1);
    n_vec++;
    if (obs_ghr != 4'b1010) begin
      n_err++; $display("FAIL repair_setup got %0h expected a", obs_ghr);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs_ghr != 4'b1101) begin
      n_err++; $display("FAIL repair_priority got %0h expected d", obs_ghr);
    end
  endtask

  task automatic test_collision();
    for (int g = 0; g < 4 && m_ctr[7] != 1; g++) cycle(0, 0, 1, 7, 0, (m_ctr[7] < 1), 0);
    cycle(0, 7 ^ m_ghr, 1, 7, 0, 1, 0);
    n_vec++;
    if (obs_taken !== 1'b0) begin
      n_err++; $display("FAIL collision_same_cycle got %0b expected 0", obs_taken);
    end
    cycle(0, 7 ^ m_ghr, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs_taken !== 1'b1) begin
      n_err++; $display("FAIL collision_next_cycle got %0b expected 1", obs_taken);
    end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++)
      cycle(1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom));
  endtask

  task automatic test_async_reset();
    b_rand = 1;
    test_random(60);
    @(negedge clk);
    uv = 1; ut = 1; pv = 1; b_uv = 1; b_ut = 1; b_pv = 1;
    #1 rst = 1'b1;
    for (int pc = 0; pc < 16; pc++) begin
      ppc = 4'(pc);
      #0.1;
      n_vec++;
      if (ptaken !== 1'b0 || pghr !== 4'h0 || pidx !== 4'(pc)) begin
        n_err++;
        $display("FAIL async_reset_a pc %0h got taken=%0b ghr=%0h idx=%0h expected 0/0/%0h",
                 pc, ptaken, pghr, pidx, pc);
      end
    end
    for (int pc = 0; pc < 64; pc++) begin
      b_ppc = 6'(pc);
      #0.1;
      n_vec++;
      if (b_ptaken !== 1'b0 || b_pghr !== 2'h0 || b_pidx !== 6'(pc)) begin
        n_err++;
        $display("FAIL async_reset_b pc %0h got taken=%0b ghr=%0h idx=%0h expected 0/0/%0h",
                 pc, b_ptaken, b_pghr, b_pidx, pc);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    pv = 0; uv = 0; um = 0; b_pv = 0; b_uv = 0; b_um = 0;
    b_rand = 0;
    model_reset();
  endtask

  // One taken update must lift a weakly-not-taken 3-bit counter (011) to taken.
  task automatic test_wide_counters();
    int idxs [4] = '{0, 17, 42, 63};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_pv = 0; b_ppc = 6'(idxs[k]); b_uv = 1; b_uidx = 6'(idxs[k]); b_ut = 1; b_um = 0;
      #1;
      n_vec++;
      if (b_ptaken !== 1'b0 || b_pidx !== 6'(idxs[k])) begin
        n_err++; $display("FAIL wide_pre idx %0d got taken=%0b idx=%0d expected 0/%0d",
                          idxs[k], b_ptaken, b_pidx, idxs[k]);
      end
      @(posedge clk);
      #1 b_uv = 0;
      #1;
      n_vec++;
      if (b_ptaken !== 1'b1 || b_pghr !== 2'h0) begin
        n_err++; $display("FAIL wide_post idx %0d got taken=%0b ghr=%0h expected 1/0",
                          idxs[k], b_ptaken, b_pghr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pv = 0; ppc = 0; uv = 0; uidx = 0; ughr = 0; ut = 0; um = 0;
    b_pv = 0; b_ppc = 0; b_uv = 0; b_uidx = 0; b_ughr = 0; b_ut = 0; b_um = 0;
    model_reset();
    test_reset();
    test_saturation();
    test_ghr_shift();
    test_repair();
    test_collision();
    test_random(300);
    test_async_reset();
    test_wide_counters();
    test_saturation();
    test_random(100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
